// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 definitions: scan codes, frame size, transmit FSM states
// and the ASCII game-key lookup used by the keyboard-emulation transmitter.
package ps2_pkg;

  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_O     = 8'h44;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_ERR,
    ST_MAKE,
    ST_GAP_F0,
    ST_BRK_F0,
    ST_GAP_CODE,
    ST_BRK_CODE,
    ST_DONE
  } tx_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] code;
  } scan_lookup_t;

  // Map a game key to its make code; anything outside the table is invalid.
  function automatic scan_lookup_t ascii_to_scan(input logic [7:0] ascii);
    scan_lookup_t r;
    // NOTE: defaults first so every path assigns r and no latch is inferred.
    r.valid = 1'b1;
    r.code  = 8'h00;
    case (ascii)
      8'h31:   r.code = SC_1;
      8'h32:   r.code = SC_2;
      8'h33:   r.code = SC_3;
      8'h34:   r.code = SC_4;
      8'h35:   r.code = SC_5;
      8'h36:   r.code = SC_6;
      8'h37:   r.code = SC_7;
      8'h38:   r.code = SC_8;
      8'h39:   r.code = SC_9;
      8'h6F:   r.code = SC_O;
      8'h78:   r.code = SC_X;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Device-side PS/2 byte serializer: start bit, 8 data bits LSB first, odd
// parity, stop bit. Each bit drives data with ps2_clk high for CLK_DIV cycles,
// then holds it with ps2_clk low for CLK_DIV cycles (22*CLK_DIV per frame).
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       finished,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]      half_cnt;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] frame;

  // Frame shift register: loaded on start, shifted one bit per bit period.
  // NOTE: no reset here; frame is only read while busy, which reset clears.
  always_ff @(posedge clk) begin
    if (!busy && start)
      frame <= {1'b1, ~^tx_byte, tx_byte, 1'b0};
    else if (busy && half_cnt == CNT_LAST && !ps2_clk)
      frame <= {1'b1, frame[FRAME_BITS-1:1]};
  end

  // Half-period divider, bit counter and registered line drivers.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      finished <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      half_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      finished <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          half_cnt <= '0;
          bit_idx  <= '0;
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b0;
        end
      end else if (half_cnt == CNT_LAST) begin
        half_cnt <= '0;
        if (ps2_clk) begin
          ps2_clk <= 1'b0;
        end else if (bit_idx == BIT_LAST) begin
          busy     <= 1'b0;
          finished <= 1'b1;
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
        end else begin
          bit_idx  <= bit_idx + 4'd1;
          ps2_clk  <= 1'b1;
          ps2_data <= frame[1];
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ascii_to_ps2_tx.sv
// ASCII game key -> PS/2 Set-2 keystroke transmitter (keyboard emulation).
// Build option BREAK_CODES_EN: when defined, each key sends make, F0, make with
// GAP_CYCLES idle cycles between frames; when undefined, only the make frame.
module ascii_to_ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_code,
  input  logic       send,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       ps2_clk,
  output logic       ps2_data
);

  tx_state_t    state;
  logic [7:0]   ascii_q;
  logic [7:0]   tx_byte;
  logic         tx_start;
  logic         tx_busy;
  logic         tx_finished;
  scan_lookup_t lookup;

`ifdef BREAK_CODES_EN
  // The finished pulse is seen one cycle late and the start request plus the
  // serializer load take one cycle each, so the counter stops 3 short of the
  // idle time on the lines. GAP_CYCLES must be at least 3.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 3);

  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       scan_q;
`endif

  assign lookup = ascii_to_scan(ascii_q);

  ps2_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_frame_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (tx_start),
    .tx_byte  (tx_byte),
    .busy     (tx_busy),
    .finished (tx_finished),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  // Keystroke sequencer: lookup, then frames and gaps; start is held until the
  // serializer reports busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      tx_byte  <= 8'h00;
      ascii_q  <= 8'h00;
`ifdef BREAK_CODES_EN
      gap_cnt  <= '0;
      scan_q   <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (tx_busy)
        tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (send && ready) begin
            ascii_q <= ascii_code;
            ready   <= 1'b0;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lookup.valid) begin
            tx_byte  <= lookup.code;
            tx_start <= 1'b1;
`ifdef BREAK_CODES_EN
            scan_q   <= lookup.code;
`endif
            state    <= ST_MAKE;
          end else begin
            err   <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_ERR: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        ST_MAKE: begin
          if (tx_finished) begin
`ifdef BREAK_CODES_EN
            gap_cnt <= '0;
            state   <= ST_GAP_F0;
`else
            done  <= 1'b1;
            state <= ST_DONE;
`endif
          end
        end
`ifdef BREAK_CODES_EN
        ST_GAP_F0: begin
          if (gap_cnt == GAP_LAST) begin
            tx_byte  <= SC_BREAK;
            tx_start <= 1'b1;
            state    <= ST_BRK_F0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_BRK_F0: begin
          if (tx_finished) begin
            gap_cnt <= '0;
            state   <= ST_GAP_CODE;
          end
        end
        ST_GAP_CODE: begin
          if (gap_cnt == GAP_LAST) begin
            tx_byte  <= scan_q;
            tx_start <= 1'b1;
            state    <= ST_BRK_CODE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_BRK_CODE: begin
          if (tx_finished) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_to_ps2_tx.sv
// Self-checking bench for ascii_to_ps2_tx (CLK_DIV=4, GAP_CYCLES=10).
// A cycle-offset model predicts every output after each accepted request;
// directed cases pin frame contents, pulse counts and reset behaviour.
module tb_ascii_to_ps2_tx;

  localparam int D         = 4;
  localparam int G         = 10;
  localparam int FRAME_CYC = 22 * D;
`ifdef BREAK_CODES_EN
  localparam int NF = 3;
`else
  localparam int NF = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] ascii_code;
  logic       ready, done, err, ps2_clk, ps2_data;

  always #5 clk = ~clk;

  ascii_to_ps2_tx #(
    .CLK_DIV    (D),
    .GAP_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ascii_code (ascii_code),
    .send       (send),
    .ready      (ready),
    .done       (done),
    .err        (err),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_lookup(input logic [7:0] a, output logic [7:0] c);
    c = 8'h00;
    case (a)
      8'h31: c = 8'h16;  8'h32: c = 8'h1E;  8'h33: c = 8'h26;
      8'h34: c = 8'h25;  8'h35: c = 8'h2E;  8'h36: c = 8'h36;
      8'h37: c = 8'h3D;  8'h38: c = 8'h3E;  8'h39: c = 8'h46;
      8'h6F: c = 8'h44;  8'h78: c = 8'h22;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Bit i of a frame: start, data LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9) return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  bit         m_act = 1'b0;
  bit         m_valid;
  logic [7:0] m_code;
  int         m_acc;
  int         edge_n = 0;
  logic       exp_ready, exp_done, exp_err, exp_clk, exp_data;
  bit         checking = 1'b0;

  always @(posedge clk) begin
    int k, s, c, last_end;
    logic [7:0] fb;
    edge_n++;
    exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0; exp_clk = 1'b1; exp_data = 1'b1;
    if (reset) begin
      m_act = 1'b0;
    end else begin
      if (!m_act && send) begin
        m_act   = 1'b1;
        m_acc   = edge_n;
        m_valid = model_lookup(ascii_code, m_code);
      end
      if (m_act) begin
        k = edge_n - m_acc;
        exp_ready = 1'b0;
        if (!m_valid) begin
          if (k == 1) exp_err = 1'b1;
          else if (k >= 2) begin m_act = 1'b0; exp_ready = 1'b1; end
        end else begin
          last_end = 2 + (NF - 1) * (FRAME_CYC + G) + FRAME_CYC;
          for (int f = 0; f < NF; f++) begin
            s  = 2 + f * (FRAME_CYC + G);
            fb = (f == 1) ? 8'hF0 : m_code;
            if (k >= s && k < s + FRAME_CYC) begin
              c        = k - s;
              exp_clk  = ((c % (2 * D)) < D);
              exp_data = frame_bit(fb, c / (2 * D));
            end
          end
          if (k == last_end + 1) exp_done = 1'b1;
          if (k >= last_end + 2) begin m_act = 1'b0; exp_ready = 1'b1; end
        end
      end
    end
  end

  // ---------------- compare and line monitor ----------------
  logic bitq[$];
  int   done_cnt = 0, err_cnt = 0, low_cyc = 0, stab_viol = 0;
  logic prev_clk = 1'b1, prev_data = 1'b1;

  always @(negedge clk) begin
    if (checking) begin
      check("ready",    ready,    exp_ready);
      check("done",     done,     exp_done);
      check("err",      err,      exp_err);
      check("ps2_clk",  ps2_clk,  exp_clk);
      check("ps2_data", ps2_data, exp_data);
    end
    if (prev_clk === 1'b1 && ps2_clk === 1'b0) bitq.push_back(ps2_data);
    if (prev_clk === 1'b0 && ps2_clk === 1'b0 && ps2_data !== prev_data) stab_viol++;
    if (ps2_clk === 1'b0) low_cyc++;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  // ---------------- helpers ----------------
  task automatic clear_capture();
    bitq.delete();
    done_cnt = 0; err_cnt = 0; low_cyc = 0; stab_viol = 0;
  endtask

  task automatic send_key(input logic [7:0] c);
    @(negedge clk);
    send = 1'b1;
    ascii_code = c;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready === 1'b1 && !m_act) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_ready", ready, 1'b1);
    @(posedge clk);
  endtask

  function automatic logic [10:0] frame_at(input int off);
    logic [10:0] v;
    for (int i = 0; i < 11; i++)
      v[i] = (off + i < bitq.size()) ? bitq[off + i] : 1'bx;
    return v;
  endfunction

  logic [7:0] keys [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                            8'h37, 8'h38, 8'h39, 8'h6F, 8'h78};

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; send = 1'b0; ascii_code = 8'h00;
    @(posedge clk);
    checking = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_clk",   ps2_clk, 1'b1);
    check("rst_data",  ps2_data, 1'b1);
    check("rst_done",  done, 1'b0);
    check("rst_err",   err, 1'b0);
    reset = 1'b0;

    // '1': make code 16 (parity 0), optional F0 and 16 break frames
    clear_capture();
    send_key(8'h31);
    wait_idle();
    check("k1_frame0", frame_at(0), 11'b100_0010_1100);
    check("k1_nbits", bitq.size(), 11 * NF);
    check("k1_low_cycles", low_cyc, 11 * D * NF);
    check("k1_done_cnt", done_cnt, 1);
    check("k1_err_cnt", err_cnt, 0);
    check("k1_data_stable", stab_viol, 0);
`ifdef BREAK_CODES_EN
    check("k1_frame1_f0", frame_at(11), 11'b111_1110_0000);
    check("k1_frame2",    frame_at(22), 11'b100_0010_1100);
`endif

    // 'o': make code 44, parity 1
    clear_capture();
    send_key(8'h6F);
    wait_idle();
    check("ko_frame0", frame_at(0), 11'b110_1000_1000);
    check("ko_done_cnt", done_cnt, 1);

    // 'A': invalid, err once, lines untouched
    clear_capture();
    send_key(8'h41);
    wait_idle();
    check("kA_err_cnt", err_cnt, 1);
    check("kA_done_cnt", done_cnt, 0);
    check("kA_nbits", bitq.size(), 0);

    // reset during bit 5 of the make frame, then a clean 'x'
    clear_capture();
    send_key(8'h78);
    begin
      int n = 0;
      while (bitq.size() < 6 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("mid_reached_bit5", bitq.size() >= 6, 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_clk",   ps2_clk, 1'b1);
    check("mid_rst_data",  ps2_data, 1'b1);
    check("mid_rst_ready", ready, 1'b1);
    reset = 1'b0;
    clear_capture();
    send_key(8'h78);
    wait_idle();
    check("kx_frame0", frame_at(0), 11'b110_0100_0100);
    check("kx_nbits", bitq.size(), 11 * NF);
    check("kx_done_cnt", done_cnt, 1);

    // send held high: exactly one keystroke per ready window
    clear_capture();
    @(negedge clk);
    send = 1'b1;
    ascii_code = 8'h35;
    begin
      int n = 0;
      while (done_cnt < 2 && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    send = 1'b0;
    wait_idle();
    check("hold_done_cnt", done_cnt, 2);
    check("hold_nbits", bitq.size(), 22 * NF);
    check("hold_data_stable", stab_viol, 0);

    // randomized traffic: valid and invalid keys, busy requests, resets
    for (int it = 0; it < 40; it++) begin
      int hold;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      ascii_code = ($urandom_range(0, 9) < 7) ? keys[$urandom_range(0, 10)]
                                              : 8'($urandom_range(0, 255));
      send = 1'b1;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 400)) : 1;
      repeat (hold) @(negedge clk);
      send = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 60)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        wait_idle();
      end
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
